// File: rtl/alu_div_sequencer_pkg.sv
// Shared ALU definitions: opcode constants and datapath width used by the ALU,
// the decoder and the divide sequencer.
package alu_div_sequencer_pkg;

    localparam int ALU_XLEN = 32;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;

endpackage

// File: rtl/alu_div_sequencer.sv
// Multi-cycle unsigned DIVU/REMU sequencer (restoring division) that borrows the
// shared EX-stage ALU on idle cycles; EX always has priority.
module alu_div_sequencer
    import alu_div_sequencer_pkg::*;
#(
    parameter int XLEN  = ALU_XLEN,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            is_rem,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            abort,
    input  logic            ex_req,
    output logic            alu_sel,
    output logic [3:0]      alu_opcode,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_y,
    output logic            busy,
    output logic            done,
    output logic            div_by_zero,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_SUB  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              hi_q, hi_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              dbz_q, dbz_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   dvs_q, dvs_d;
    logic              is_rem_q, is_rem_d;

    logic              rem_hi;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   quo_sh;
    logic [XLEN-1:0]   quo_set;
    logic [CNT_W-1:0]  cnt_dec;
    logic [CNT_W-1:0]  cnt_nxt;

    // Shift view of the partial remainder: {rem_hi, rem_s} = {rem, quo msb}
    assign rem_hi  = rem_q[XLEN-1];
    assign rem_s   = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
    assign quo_sh  = {quo_q[XLEN-2:0], 1'b0};
    assign quo_set = {quo_q[XLEN-1:1], 1'b1};
    assign cnt_dec = cnt_q - CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        dbz_d      = dbz_q;
        result_d   = result_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        is_rem_d   = is_rem_q;
        cnt_nxt    = cnt_q;
        alu_sel    = 1'b0;
        alu_opcode = 4'b0000;
        alu_a      = '0;
        alu_b      = '0;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    is_rem_d = is_rem;
                    busy_d   = 1'b1;
                    if (divisor != '0) begin
                        rem_d   = '0;
                        quo_d   = dividend;
                        dvs_d   = divisor;
                        cnt_d   = CNT_W'(XLEN);
                        hi_d    = 1'b0;
                        dbz_d   = 1'b0;
                        state_d = S_CMP;
                    end else begin
                        result_d = is_rem ? dividend : '1;
                        dbz_d    = 1'b1;
                        done_d   = 1'b1;
                        state_d  = S_DONE;
                    end
                end
            end
            S_CMP: begin
                if (rem_hi) begin
                    // Shifted value exceeds XLEN bits, so it is certainly >= divisor
                    rem_d   = rem_s;
                    quo_d   = quo_sh;
                    hi_d    = 1'b1;
                    state_d = S_SUB;
                end else if (!ex_req) begin
                    alu_sel    = 1'b1;
                    alu_opcode = ALU_SLTU;
                    alu_a      = rem_s;
                    alu_b      = dvs_q;
                    rem_d      = rem_s;
                    quo_d      = quo_sh;
                    cnt_d      = cnt_dec;
                    hi_d       = 1'b0;
                    if (alu_y[0]) begin
                        if (cnt_dec == '0) begin
                            result_d = is_rem_q ? rem_s : quo_sh;
                            done_d   = 1'b1;
                            state_d  = S_DONE;
                        end
                    end else begin
                        state_d = S_SUB;
                    end
                end
            end
            S_SUB: begin
                if (!ex_req) begin
                    alu_sel    = 1'b1;
                    alu_opcode = ALU_SUB;
                    alu_a      = rem_q;
                    alu_b      = dvs_q;
                    cnt_nxt    = hi_q ? cnt_dec : cnt_q;
                    rem_d      = alu_y;
                    quo_d      = quo_set;
                    cnt_d      = cnt_nxt;
                    hi_d       = 1'b0;
                    if (cnt_nxt == '0) begin
                        result_d = is_rem_q ? alu_y : quo_set;
                        done_d   = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        state_d = S_CMP;
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        // Flush kills the op and leaves the visible result untouched
        if (abort && state_q != S_IDLE) begin
            state_d    = S_IDLE;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            dbz_d      = dbz_q;
            result_d   = result_q;
            alu_sel    = 1'b0;
            alu_opcode = 4'b0000;
            alu_a      = '0;
            alu_b      = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
            result_q <= result_d;
        end
    end

    always_ff @(posedge clk) begin
        rem_q    <= rem_d;
        quo_q    <= quo_d;
        dvs_q    <= dvs_d;
        is_rem_q <= is_rem_d;
    end

    assign busy        = busy_q;
    assign done        = done_q & ~abort;
    assign div_by_zero = dbz_q;
    assign result      = result_q;

endmodule

// File: tb/tb_alu_div_sequencer.sv
// Randomized self-checking bench for alu_div_sequencer against an arithmetic
// reference (/, %, popcount latency) with a behavioural ALU and EX-stage traffic.
module tb_alu_div_sequencer;
    import alu_div_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, is_rem, abort, ex_req;
    logic [31:0] dividend, divisor;
    logic        alu_sel;
    logic [3:0]  alu_opcode;
    logic [31:0] alu_a, alu_b, alu_y;
    logic        busy, done, div_by_zero;
    logic [31:0] result;
    logic [31:0] noise;

    int n_vec = 0;
    int n_err = 0;

    alu_div_sequencer #(.XLEN(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .is_rem(is_rem),
        .dividend(dividend), .divisor(divisor), .abort(abort), .ex_req(ex_req),
        .alu_sel(alu_sel), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_y(alu_y), .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .result(result)
    );

    always #5 clk = ~clk;

    // When the sequencer does not own the ALU, the EX stage's result shows up instead
    always @(posedge clk) noise <= $urandom;

    assign alu_y = !alu_sel ? noise :
                   (alu_opcode == ALU_SUB)  ? alu_a - alu_b :
                   (alu_opcode == ALU_SLTU) ? {31'b0, alu_a < alu_b} :
                                              alu_a + alu_b;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic pick_ex(input int mode, input int cyc);
        case (mode)
            1:       return ($urandom_range(0, 3) == 0);
            2:       return (cyc >= 5 && cyc < 15);
            default: return 1'b0;
        endcase
    endfunction

    // One operation; the expected done cycle is the first cycle at which
    // 32+popcount(q) ALU-free-of-EX cycles have elapsed since launch.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic rem,
                         input int mode, input int abort_at, input int poke_at, input string tag);
        logic [31:0] q, r, exp, prev;
        int need, work, cyc, done_cyc, exp_cyc;
        q    = (b == 0) ? 32'hFFFF_FFFF : a / b;
        r    = (b == 0) ? a : a % b;
        exp  = rem ? r : q;
        need = (b == 0) ? 0 : 32 + $countones(q);
        prev = result;
        start = 1'b1; dividend = a; divisor = b; is_rem = rem; ex_req = 1'b0; abort = 1'b0;
        work = 0; cyc = 0; done_cyc = -1; exp_cyc = -1;
        while (cyc < 400 && done_cyc < 0 && (abort_at < 0 || cyc <= abort_at)) begin
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            if (cyc == poke_at) begin
                start = 1'b1; dividend = a ^ 32'h5A5A_0F0F; divisor = b + 32'd3; is_rem = ~rem;
            end
            abort  = (cyc == abort_at);
            ex_req = pick_ex(mode, cyc);
            if (cyc == abort_at && mode == 2) ex_req = 1'b1;
            if (exp_cyc < 0 && work == need) exp_cyc = cyc;
            if (exp_cyc < 0 && !ex_req) work++;
            #1;
            check({tag, "_alu_excl"}, {31'b0, alu_sel & ex_req}, 32'd0);
            if (cyc == 1) check({tag, "_busy1"}, {31'b0, busy}, 32'd1);
            if (done) done_cyc = cyc;
        end
        start = 1'b0; abort = 1'b0; ex_req = 1'b0;
        if (abort_at >= 0 && done_cyc < 0 && cyc > abort_at) begin
            check({tag, "_abort_idle"}, {31'b0, busy}, 32'd0);
            if (exp_cyc < 0) check({tag, "_abort_res"}, result, prev);
        end else if (abort_at >= 0) begin
            check({tag, "_abort_nodone"}, done_cyc, -1);
        end else begin
            check({tag, "_lat"}, done_cyc, exp_cyc);
            check({tag, "_res"}, result, exp);
            check({tag, "_dbz"}, {31'b0, div_by_zero}, {31'b0, b == 0});
            @(posedge clk); #2;
            check({tag, "_pulse"}, {31'b0, done}, 32'd0);
            check({tag, "_idle"}, {31'b0, busy}, 32'd0);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_done"}, {31'b0, done}, 32'd0);
        check({tag, "_dbz"}, {31'b0, div_by_zero}, 32'd0);
        check({tag, "_res"}, result, 32'd0);
        check({tag, "_sel"}, {31'b0, alu_sel}, 32'd0);
        check({tag, "_alu"}, {28'b0, alu_opcode} | alu_a | alu_b, 32'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        rst = 1'b1; start = 1'b0; is_rem = 1'b0; abort = 1'b0; ex_req = 1'b0;
        dividend = '0; divisor = '0;
        #12;
        check_reset_state("rst0");
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        do_op(32'd100, 32'd7, 1'b0, 0, -1, -1, "q100_7");
        do_op(32'd100, 32'd7, 1'b1, 0, -1, -1, "r100_7");
        do_op(32'h1234, 32'd0, 1'b0, 0, -1, -1, "dz_q");
        do_op(32'h1234, 32'd0, 1'b1, 0, -1, -1, "dz_r");
        do_op(32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 0, -1, -1, "big_q");
        do_op(32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 0, -1, -1, "big_r");
        do_op(32'd100, 32'd7, 1'b0, 2, -1, -1, "stall10");
        do_op(32'd100, 32'd7, 1'b0, 0, 20, -1, "abort20");
        do_op(32'd100, 32'd7, 1'b1, 0, -1, -1, "after_abort");
        do_op(32'd1000, 32'd3, 1'b0, 2, 10, -1, "abort_exreq");
        do_op(32'd100, 32'd7, 1'b0, 0, 36, -1, "abort_done");
        do_op(32'd100, 32'd7, 1'b0, 0, -1, 10, "poke");

        // start together with abort in IDLE is dropped
        start = 1'b1; abort = 1'b1; dividend = 32'd9; divisor = 32'd2;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        #1 check("start_abort_idle", {31'b0, busy}, 32'd0);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1, 2:    rb = $urandom_range(1, 15);
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            do_op(ra, rb, 1'(($urandom_range(0, 1))), 1, -1, -1, "rand");
        end

        // asynchronous reset mid-operation clears every output
        start = 1'b1; dividend = 32'd100; divisor = 32'd7; is_rem = 1'b0;
        @(posedge clk); #1; start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1 check_reset_state("rst_mid");
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        do_op(32'd77, 32'd5, 1'b1, 0, -1, -1, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
